// File: rtl/bitpattern_pkg.sv
// Shared types and default constants for the serial pattern detector.
package bitpattern_pkg;

  // Detector FSM states: filling the window, hunting for a match, matched.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HUNT  = 2'd1,
    MATCH = 2'd2
  } state_t;

  localparam int                       DEFAULT_WIDTH   = 3;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_PATTERN = 3'b101;

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, never wraps.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count register with saturation at the maximum code.
  always_ff @(posedge clock or negedge nreset) begin
    // NOTE: sequential state is updated with <= so every register in the
    // design sees the pre-edge values of the others, regardless of block order.
    if (!nreset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: shifts inp into a WIDTH-bit window, raises a
// Moore flag when the full window equals PATTERN, and counts matches.
module pattern_detector
  import bitpattern_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN),
  parameter int               OVERLAP = 1,
  parameter int               COUNT_W = 8
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               en,
  input  logic               inp,
  output logic               outp,
  output logic [COUNT_W-1:0] match_count
);

  // Fill counter must hold 0..WIDTH inclusive.
  localparam int               FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  hist;
  logic [WIDTH-1:0]  hist_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic              match_inc;

  // Next-state decode for window, fill level and FSM state on a sample edge.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the
    // block leaves one unassigned and no latch is inferred.
    hist_next  = hist;
    fill_next  = fill;
    state_next = state;
    if (en) begin
      if ((OVERLAP == 0) && (state == MATCH)) begin
        // Non-overlapping: the matched bits are consumed; only the new bit
        // starts the next window.
        hist_next  = WIDTH'(inp);
        fill_next  = FILL_W'(1);
        state_next = FILL;
      end else begin
        hist_next = {hist[WIDTH-2:0], inp};
        fill_next = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        if (fill_next == FILL_FULL) begin
          state_next = (hist_next == PATTERN) ? MATCH : HUNT;
        end else begin
          state_next = FILL;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // History window and fill level registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_next;
      fill <= fill_next;
    end
  end

  // Every sampled entry into MATCH (including MATCH->MATCH) is one match.
  assign match_inc = en && (state_next == MATCH);

  // Moore flag decoded purely from the state register.
  assign outp = (state == MATCH);

  sat_counter #(
    .WIDTH(COUNT_W)
  ) u_match_counter (
    .clock (clock),
    .nreset(nreset),
    .inc   (match_inc),
    .count (match_count)
  );

endmodule
